// File: rtl/sys_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_bridge_pkg
// Brief    : Shared state encoding, access-size codes and lane helpers for
//            the processor-to-device bridge.
// Revision : 1.0
// ============================================================================
package sys_bridge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned CPU data is copied onto every lane the access could use.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{wd[7:0]}};
      SZ_HALF: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bridge_decode.sv
`default_nettype none
// ============================================================================
// Module   : bridge_decode
// Brief    : Combinational device-space decode: one-hot slot, hit flag,
//            size/alignment legality and word offset within the slot.
// Revision : 1.0
// ============================================================================
module bridge_decode
  import sys_bridge_pkg::*;
#(
  parameter int unsigned DEV_NUM       = 2,
  parameter logic [31:0] DEV_BASE      = 32'h0000_7F00,
  parameter int unsigned DEV_SPAN_LOG2 = 4
) (
  input  logic [31:0]              i_addr,
  input  logic [1:0]               i_size,
  output logic [DEV_NUM-1:0]       o_sel,
  output logic                     o_hit,
  output logic                     o_aligned,
  output logic [DEV_SPAN_LOG2-3:0] o_woff
);

  localparam logic [31:0] c_limit = 32'(DEV_NUM) << DEV_SPAN_LOG2;

  logic [31:0] w_off;

  assign w_off  = i_addr - DEV_BASE;
  assign o_hit  = (i_addr >= DEV_BASE) && (w_off < c_limit);
  assign o_woff = w_off[DEV_SPAN_LOG2-1:2];

  // Illegal size is folded into the alignment flag so the caller sees one "ok".
  always_comb begin
    case (i_size)
      SZ_BYTE: o_aligned = 1'b1;
      SZ_HALF: o_aligned = ~i_addr[0];
      SZ_WORD: o_aligned = (i_addr[1:0] == 2'b00);
      default: o_aligned = 1'b0;
    endcase
  end

  for (genvar k = 0; k < DEV_NUM; k++) begin : g_sel
    assign o_sel[k] = o_hit && ((w_off >> DEV_SPAN_LOG2) == 32'(k));
  end

endmodule
`default_nettype wire

// File: rtl/sys_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sys_bridge
// Brief    : CPU-to-device bridge with sized accesses, ack handshake and
//            interrupt collection. Define SYS_BRIDGE_TIMEOUT_EN to enable the
//            ACCESS-state timeout.
// Revision : 1.0
// ============================================================================
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int unsigned DEV_NUM       = 2,
  parameter logic [31:0] DEV_BASE      = 32'h0000_7F00,
  parameter int unsigned DEV_SPAN_LOG2 = 4,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              PrAddr,
  input  logic [1:0]               PrSize,
  input  logic                     PrReq,
  input  logic                     PrWe,
  input  logic [31:0]              PrWD,
  output logic [31:0]              PrRD,
  output logic                     PrRdy,
  output logic                     PrErr,
  output logic [5:0]               HWInt,
  output logic [DEV_SPAN_LOG2-3:0] DevAddr,
  output logic [31:0]              DevWD,
  output logic [3:0]               DevBE,
  output logic [DEV_NUM-1:0]       DevSel,
  output logic [DEV_NUM-1:0]       DevWe,
  input  logic [32*DEV_NUM-1:0]    DevRD,
  input  logic [DEV_NUM-1:0]       DevAck,
  input  logic [DEV_NUM-1:0]       DevIrq
);

  logic [1:0]               r_state, w_next;
  logic [DEV_NUM-1:0]       r_slot, w_sel, r_irq;
  logic                     r_we, w_hit, w_aligned, w_ok, w_ack, w_tmo;
  logic [DEV_SPAN_LOG2-3:0] r_addr, w_woff;
  logic [3:0]               r_be;
  logic [31:0]              r_wd, r_prrd, w_rd;

  bridge_decode #(
    .DEV_NUM       (DEV_NUM),
    .DEV_BASE      (DEV_BASE),
    .DEV_SPAN_LOG2 (DEV_SPAN_LOG2)
  ) u_decode (
    .i_addr    (PrAddr),
    .i_size    (PrSize),
    .o_sel     (w_sel),
    .o_hit     (w_hit),
    .o_aligned (w_aligned),
    .o_woff    (w_woff)
  );

  assign w_ok  = w_hit & w_aligned;
  assign w_ack = |(DevAck & r_slot);

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < DEV_NUM; k++) begin
      if (r_slot[k]) w_rd = DevRD[32*k +: 32];
    end
  end

`ifdef SYS_BRIDGE_TIMEOUT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_cnt <= '0;
    else if (r_state != ST_ACCESS) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 8'd1;
  end

  assign w_tmo = (r_cnt == 8'(TIMEOUT - 1));
`else
  // TIMEOUT is at least 1, so this never fires: ACCESS waits for ack forever.
  assign w_tmo = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (PrReq) w_next = w_ok ? ST_ACCESS : ST_ERR;
      ST_ACCESS: begin
        if (w_ack)      w_next = ST_DONE;
        else if (w_tmo) w_next = ST_ERR;
      end
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    PrRdy  = 1'b0;
    PrErr  = 1'b0;
    DevSel = '0;
    DevWe  = '0;
    case (r_state)
      ST_ACCESS: begin
        DevSel = r_slot;
        DevWe  = r_slot & {DEV_NUM{r_we}};
      end
      ST_DONE: PrRdy = 1'b1;
      ST_ERR: begin
        PrRdy = 1'b1;
        PrErr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_wd   <= '0;
      r_prrd <= '0;
    end else begin
      if (r_state == ST_IDLE && PrReq && w_ok) begin
        r_slot <= w_sel;
        r_we   <= PrWe;
        r_addr <= w_woff;
        r_be   <= gen_be(PrSize, PrAddr[1:0]);
        r_wd   <= replicate(PrSize, PrWD);
      end
      if (r_state == ST_ACCESS && w_ack && !r_we) r_prrd <= w_rd;
      if (w_next == ST_ERR) r_prrd <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= '0;
    else      r_irq <= DevIrq;
  end

  for (genvar k = 0; k < 6; k++) begin : g_hwint
    if (k < DEV_NUM) begin : g_dev
      assign HWInt[k] = r_irq[k];
    end else begin : g_tie
      assign HWInt[k] = 1'b0;
    end
  end

  assign PrRD    = r_prrd;
  assign DevAddr = r_addr;
  assign DevBE   = r_be;
  assign DevWD   = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_bridge
// Brief    : Self-checking bench for sys_bridge: directed cases plus random
//            accesses against a spec-level reference model.
// Revision : 1.0
// ============================================================================
module tb_sys_bridge;

  localparam int unsigned DEV_NUM  = 2;
  localparam logic [31:0] DEV_BASE = 32'h0000_7F00;
  localparam int unsigned SPAN     = 16;
  localparam int unsigned TMO      = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PrAddr = '0;
  logic [1:0]  PrSize = '0;
  logic        PrReq = 1'b0;
  logic        PrWe = 1'b0;
  logic [31:0] PrWD = '0;
  logic [31:0] PrRD;
  logic        PrRdy, PrErr;
  logic [5:0]  HWInt;
  logic [1:0]  DevAddr;
  logic [31:0] DevWD;
  logic [3:0]  DevBE;
  logic [1:0]  DevSel, DevWe;
  logic [63:0] DevRD = '0;
  logic [1:0]  DevAck = '0;
  logic [1:0]  DevIrq = '0;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] exp_prrd = '0;

  sys_bridge #(
    .DEV_NUM       (DEV_NUM),
    .DEV_BASE      (DEV_BASE),
    .DEV_SPAN_LOG2 (4),
    .TIMEOUT       (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .PrAddr  (PrAddr),
    .PrSize  (PrSize),
    .PrReq   (PrReq),
    .PrWe    (PrWe),
    .PrWD    (PrWD),
    .PrRD    (PrRD),
    .PrRdy   (PrRdy),
    .PrErr   (PrErr),
    .HWInt   (HWInt),
    .DevAddr (DevAddr),
    .DevWD   (DevWD),
    .DevBE   (DevBE),
    .DevSel  (DevSel),
    .DevWe   (DevWe),
    .DevRD   (DevRD),
    .DevAck  (DevAck),
    .DevIrq  (DevIrq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One CPU access; the slave acks after 'waits' extra cycles.
  task automatic do_access(input logic [31:0] addr, input logic [1:0] size, input logic we,
                           input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    logic [31:0] off, dwd;
    logic        ok;
    int          slot;
    logic [1:0]  sel_exp;
    logic [3:0]  be;
    off = addr - DEV_BASE;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (addr % 2) == 0;
      2'd2:    ok = (addr % 4) == 0;
      default: ok = 1'b0;
    endcase
    ok      = ok && (addr >= DEV_BASE) && (off < DEV_NUM * SPAN);
    slot    = int'(off / SPAN);
    sel_exp = 2'(1 << slot);
    case (size)
      2'd0:    begin be = 4'(1 << (addr % 4)); dwd = {4{wd[7:0]}}; end
      2'd1:    begin be = ((addr % 4) >= 2) ? 4'b1100 : 4'b0011; dwd = {2{wd[15:0]}}; end
      default: begin be = 4'b1111; dwd = wd; end
    endcase

    PrAddr = addr; PrSize = size; PrWe = we; PrWD = wd; PrReq = 1'b1;
    tick;
    if (!ok) begin
      exp_prrd = '0;
      check("err_rdy", 32'(PrRdy), 32'd1);
      check("err_flag", 32'(PrErr), 32'd1);
      check("err_sel", 32'(DevSel), 32'd0);
      check("err_prrd", PrRD, exp_prrd);
      PrReq = 1'b0;
      tick;
      check("err_idle", 32'(PrRdy), 32'd0);
      return;
    end
    check("acc_sel", 32'(DevSel), 32'(sel_exp));
    check("acc_we", 32'(DevWe), we ? 32'(sel_exp) : 32'd0);
    check("acc_be", 32'(DevBE), 32'(be));
    check("acc_wd", DevWD, dwd);
    check("acc_addr", 32'(DevAddr), (off % SPAN) / 4);
    for (int i = 0; i <= waits; i++) begin
      DevRD = {$urandom, $urandom};
      DevRD[32*slot +: 32] = rdata;
      if (i == waits) DevAck = sel_exp;
      else            DevAck = ($urandom_range(0, 1) == 1) ? ~sel_exp : 2'b00;
      tick;
      DevAck = 2'b00;
      if (i < waits) begin
        check("wait_sel", 32'(DevSel), 32'(sel_exp));
        check("wait_rdy", 32'(PrRdy), 32'd0);
      end
    end
    if (!we) exp_prrd = rdata;
    check("done_rdy", 32'(PrRdy), 32'd1);
    check("done_err", 32'(PrErr), 32'd0);
    check("done_prrd", PrRD, exp_prrd);
    PrReq = 1'b0;
    tick;
    check("idle_rdy", 32'(PrRdy), 32'd0);
    check("idle_sel", 32'(DevSel), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r, early;
    logic [1:0]  v;

    #1;
    check("rst_prrd", PrRD, 32'd0);
    check("rst_rdy", 32'(PrRdy), 32'd0);
    check("rst_err", 32'(PrErr), 32'd0);
    check("rst_sel", 32'(DevSel), 32'd0);
    check("rst_we", 32'(DevWe), 32'd0);
    check("rst_be", 32'(DevBE), 32'd0);
    check("rst_wd", DevWD, 32'd0);
    check("rst_addr", 32'(DevAddr), 32'd0);
    check("rst_hwint", 32'(HWInt), 32'd0);
    tick; tick;
    rst = 1'b1;
    tick;

    do_access(32'h7F04, 2'b10, 1'b0, 32'h0, 0, 32'hDEADBEEF);
    do_access(32'h7F13, 2'b00, 1'b1, 32'h0000_00A5, 0, 32'h1234_5678);
    do_access(32'h7F18, 2'b10, 1'b0, 32'h0, 5, 32'hCAFE_F00D);
    do_access(32'h7F1A, 2'b01, 1'b1, 32'h1234_BEEF, 2, 32'h0);
    do_access(32'h7F01, 2'b01, 1'b0, 32'h0, 0, 32'h0);
    do_access(32'h8000, 2'b10, 1'b0, 32'h0, 0, 32'h0);
    do_access(32'h7F08, 2'b11, 1'b0, 32'h0, 0, 32'h0);

    DevIrq = 2'b01;
    check("irq_lat", 32'(HWInt), 32'd0);
    tick;
    check("irq_one", 32'(HWInt), 32'h01);
    for (int i = 0; i < 4; i++) begin
      v = 2'($urandom_range(0, 3));
      DevIrq = v;
      tick;
      check("irq_rand", 32'(HWInt), 32'(v));
    end

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r < 8)       a = DEV_BASE + $urandom_range(0, 31);
      else if (r == 8) a = DEV_BASE + 32 + $urandom_range(0, 255);
      else             a = DEV_BASE - 1 - $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) a = a & ~32'd3;
        if (sz == 2'b01) a = a & ~32'd1;
      end
      do_access(a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4), $urandom);
    end

    DevIrq = 2'b11;
    PrAddr = 32'h7F00; PrSize = 2'b10; PrWe = 1'b0; PrReq = 1'b1;
    tick;
    check("hang_sel0", 32'(DevSel), 32'd1);
`ifdef SYS_BRIDGE_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) tick;
    check("tmo_sel_last", 32'(DevSel), 32'd1);
    check("tmo_rdy_early", 32'(PrRdy), 32'd0);
    tick;
    check("tmo_rdy", 32'(PrRdy), 32'd1);
    check("tmo_err", 32'(PrErr), 32'd1);
    check("tmo_prrd", PrRD, 32'd0);
    check("tmo_sel", 32'(DevSel), 32'd0);
    tick;
    tick;
    check("tmo_restart_sel", 32'(DevSel), 32'd1);
`else
    early = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (PrRdy) early++;
    end
    check("hang_sel", 32'(DevSel), 32'd1);
    check("hang_rdy_seen", 32'(early), 32'd0);
`endif
    check("pre_rst_hwint", 32'(HWInt), 32'h03);
    rst = 1'b0;
    #1;
    check("mid_rst_sel", 32'(DevSel), 32'd0);
    check("mid_rst_be", 32'(DevBE), 32'd0);
    check("mid_rst_prrd", PrRD, 32'd0);
    check("mid_rst_hwint", 32'(HWInt), 32'd0);
    PrReq = 1'b0;
    exp_prrd = '0;
    tick;
    rst = 1'b1;
    tick;
    do_access(32'h7F1C, 2'b10, 1'b0, 32'h0, 1, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sys_bridge.md
# sys_bridge

Parametrised processor-to-device system bridge between the multicycle MIPS core and up to six memory-mapped peripherals. It decodes the CPU's device-space address, generates byte enables from access size and offset, and runs a select/acknowledge handshake with wait states and timeout. It also collects device interrupt lines onto the core's `HWInt[7:2]` bus. It replaces the fixed `BE = 4'b1111` word-only path with sized, stallable accesses.

## Interface
- `DEV_NUM`, 2: number of device slots, 1..6.
- `DEV_BASE`, 32'h0000_7F00: byte address of slot 0; slot k at `DEV_BASE + k*2^DEV_SPAN_LOG2`.
- `DEV_SPAN_LOG2`, 4: log2 of bytes per slot, 3..8.
- `TIMEOUT`, 15: ACCESS cycles without ack before error, 1..255.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `PrAddr` in 32: CPU byte address.
- `PrSize` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `PrReq` in 1: access request, held until `PrRdy`.
- `PrWe` in 1: 1 write, 0 read.
- `PrWD` in 32: write data, right-aligned (bits [7:0] for byte).
- `PrRD` out 32: read word, raw lane order.
- `PrRdy` out 1: one-cycle completion pulse.
- `PrErr` out 1: qualifies `PrRdy`, access failed.
- `HWInt` out 6: interrupt bus to CP0 (`[7:2]`).
- `DevAddr` out DEV_SPAN_LOG2-2: word offset within slot.
- `DevWD` out 32: lane-replicated write data.
- `DevBE` out 4: byte enables.
- `DevSel` out DEV_NUM: one-hot select.
- `DevWe` out DEV_NUM: one-hot write strobe, subset of `DevSel`.
- `DevRD` in 32*DEV_NUM: slot k read data at `[32k+31:32k]`.
- `DevAck` in DEV_NUM: per-slot acknowledge.
- `DevIrq` in DEV_NUM: level-sensitive device interrupts.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE: `PrReq` sampled. Decode hit = address within `[DEV_BASE, DEV_BASE + DEV_NUM*2^DEV_SPAN_LOG2)`.
- Alignment: half needs `PrAddr[0]=0`, word needs `[1:0]=0`.
- Hit and aligned and size legal -> latch slot, `DevAddr`, `DevBE`, `DevWD`, go ACCESS. Otherwise go ERR.
- Byte enables: byte `1<<a[1:0]`; half `a[1]?1100:0011`; word `1111`.
- Write data: byte replicated to four lanes; half replicated to two lanes; word passed through.
- ACCESS: `DevSel[k]`=1, `DevWe[k]`=`PrWe`, all outputs stable. On `DevAck[k]`, capture `DevRD` slot k into `PrRD` (writes leave `PrRD` unchanged), go DONE. Acks from unselected slots are ignored.
- DONE: `PrRdy`=1, `PrErr`=0, go IDLE.
- ERR: `PrRdy`=1, `PrErr`=1, `PrRD`=0, go IDLE.
- Interrupts: `HWInt[k]` = registered `DevIrq[k]` for k < DEV_NUM; upper bits tied 0.
- Read lane extraction and sign extension remain in the core; the bridge does none.

## Timing
- Reset (async, `rst`=0): state IDLE. `PrRD`, `PrRdy`, `PrErr`, `HWInt`, `DevSel`, `DevWe`, `DevBE`, `DevWD`, `DevAddr` all 0, taking effect immediately. A reset during ACCESS drops `DevSel` without waiting for ack.
- Request in IDLE at edge N -> `DevSel` high in cycle N+1.
- Ack sampled in cycle N+1 -> `PrRdy` in cycle N+2. Minimum latency is 2 cycles; each extra wait cycle adds 1.
- Decode/alignment error -> `PrRdy`+`PrErr` in cycle N+1.
- `PrReq` is only sampled in IDLE. A still-high `PrReq` in the cycle after `PrRdy` starts a new access, giving back-to-back throughput of one access per 3 cycles.
- Timeout counter is 8-bit, cleared on entering ACCESS.
- Ack and timeout expiry on the same cycle: ack wins, go DONE.
- `HWInt` latency is 1 cycle from `DevIrq`.

## Configuration
- `SYS_BRIDGE_TIMEOUT_EN` defined: the counter runs. After `TIMEOUT` ACCESS cycles with no ack, `DevSel` drops and the FSM goes ERR.
- Not defined: no counter; ACCESS waits indefinitely for ack, and `TIMEOUT` is ignored.

## Structure
- Package `sys_bridge_pkg`: state encoding, size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), BE-generation function, lane-replication function.
- Sub-module `bridge_decode`: combinational address -> one-hot slot plus hit/align flags, parametrised by `DEV_NUM`, `DEV_BASE`, `DEV_SPAN_LOG2`.
- FSM, datapath latches and interrupt register live in `sys_bridge`.

## Test plan
- Word read: `PrAddr`=0x7F04, size 10, slot 0 acks in cycle 1 with 0xDEADBEEF -> `DevAddr`=1, `DevBE`=1111, `PrRD`=0xDEADBEEF, `PrRdy` 2 cycles after request, `PrErr`=0.
- Byte write: `PrAddr`=0x7F13, size 00, `PrWD`=0xA5 -> `DevSel`=10, `DevWe`=10, `DevBE`=1000, `DevWD`=0xA5A5A5A5.
- Wait states: slot 1 acks after 5 cycles -> `DevSel` held 6 cycles, `PrRdy` 7 cycles after request.
- Errors: half at 0x7F01 or word at 0x8000 -> `PrRdy`=`PrErr`=1 next cycle, no `DevSel` pulse.
- Timeout (macro on, `TIMEOUT`=15): no ack -> `PrErr` after 15 ACCESS cycles, `PrRD`=0. With the macro off, the FSM is still in ACCESS after 100 cycles.
- Reset and IRQ: `rst` low mid-ACCESS clears `DevSel` immediately. `DevIrq`=01 -> `HWInt`=000001 one cycle later, upper bits 0.
